// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the RV32C datapath: owns pc/ir, sequences C.ADDI through FETCH/EXEC/WB.
// Optional macro SEQ_C_LI_EN additionally accepts C.LI as a legal encoding.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          RET_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step_req,
    output logic             step_ack,
    input  logic             illegal_clr,
    output logic             halted,
    output logic             illegal,
    output logic [31:0]      pc,
    input  logic [15:0]      inst,
    output logic [4:0]       reg_sel,
    input  logic [31:0]      reg_rdata,
    output logic [31:0]      reg_wdata,
    output logic             reg_we,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t             state_r;
    logic [31:0]        pc_r;
    logic [15:0]        ir_r;
    logic [31:0]        result_r;
    logic [RET_W-1:0]   retired_r;
    logic               illegal_r;
    logic               stepping_r;
    logic               step_prev_r;
    logic               step_ack_r;

    logic               step_edge_s;
    logic [31:0]        imm_s;
    logic [31:0]        exec_result_s;
    logic               legal_s;

    function automatic logic is_c_addi(input logic [15:0] ir);
        return (ir[1:0] == 2'b01) && (ir[15:13] == 3'b000);
    endfunction

    function automatic logic is_c_li(input logic [15:0] ir);
        return (ir[1:0] == 2'b01) && (ir[15:13] == 3'b010);
    endfunction

    assign step_edge_s = step_req & ~step_prev_r;
    assign imm_s       = {{27{ir_r[12]}}, ir_r[6:2]};

    // Decode legality and compute the value written back in WB.
    always_comb begin
        legal_s       = 1'b0;
        exec_result_s = 32'd0;
        if (is_c_addi(ir_r)) begin
            legal_s       = 1'b1;
            exec_result_s = reg_rdata + imm_s;
`ifdef SEQ_C_LI_EN
        end else if (is_c_li(ir_r)) begin
            legal_s       = 1'b1;
            exec_result_s = imm_s;
`endif
        end else begin
            legal_s       = 1'b0;
            exec_result_s = 32'd0;
        end
    end

    // Sequencer state, architectural registers and host-visible flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= S_HALT;
            pc_r        <= RESET_PC;
            ir_r        <= 16'd0;
            result_r    <= 32'd0;
            retired_r   <= '0;
            illegal_r   <= 1'b0;
            stepping_r  <= 1'b0;
            step_prev_r <= 1'b0;
            step_ack_r  <= 1'b0;
        end else begin
            step_prev_r <= step_req;
            step_ack_r  <= 1'b0;
            case (state_r)
                S_HALT: begin
                    if (illegal_clr) begin
                        illegal_r <= 1'b0;
                    end
                    // Exits are judged on the flag as it stood entering this cycle.
                    if (!illegal_r) begin
                        if (run) begin
                            state_r    <= S_FETCH;
                            stepping_r <= 1'b0;
                        end else if (step_edge_s) begin
                            state_r    <= S_FETCH;
                            stepping_r <= 1'b1;
                        end else begin
                            state_r <= S_HALT;
                        end
                    end else begin
                        state_r <= S_HALT;
                    end
                end
                S_FETCH: begin
                    ir_r    <= inst;
                    state_r <= S_EXEC;
                end
                S_EXEC: begin
                    if (legal_s) begin
                        result_r <= exec_result_s;
                        state_r  <= S_WB;
                    end else begin
                        // A faulting step ends here, so no ack will follow.
                        illegal_r  <= 1'b1;
                        stepping_r <= 1'b0;
                        state_r    <= S_HALT;
                    end
                end
                S_WB: begin
                    pc_r      <= pc_r + 32'd2;
                    retired_r <= retired_r + {{(RET_W-1){1'b0}}, 1'b1};
                    if (stepping_r) begin
                        stepping_r <= 1'b0;
                        step_ack_r <= 1'b1;
                        state_r    <= S_HALT;
                    end else if (run) begin
                        state_r <= S_FETCH;
                    end else begin
                        state_r <= S_HALT;
                    end
                end
                default: begin
                    state_r <= S_HALT;
                end
            endcase
        end
    end

    // State-decoded outputs; no combinational path from any input.
    always_comb begin
        halted  = (state_r == S_HALT);
        reg_we  = (state_r == S_WB) && (ir_r[11:7] != 5'd0);
        if ((state_r == S_EXEC) || (state_r == S_WB)) begin
            reg_sel = ir_r[11:7];
        end else begin
            reg_sel = 5'd0;
        end
    end

    assign pc        = pc_r;
    assign reg_wdata = result_r;
    assign retired   = retired_r;
    assign illegal   = illegal_r;
    assign step_ack  = step_ack_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small pmem array and register-file model.
module tb_cpu_sequencer;

    logic        clock;
    logic        reset;
    logic        run;
    logic        step_req;
    logic        step_ack;
    logic        illegal_clr;
    logic        halted;
    logic        illegal;
    logic [31:0] pc;
    logic [15:0] inst;
    logic [4:0]  reg_sel;
    logic [31:0] reg_rdata;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic [31:0] retired;

    logic [15:0] pmem [16];
    logic [31:0] rf   [32];

    int total_cnt;
    int bad_cnt;
    int ack_cnt;
    int we_cnt;
    int ack_base;
    int we_base;

    cpu_sequencer #(.RESET_PC(32'd0), .RET_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .step_req   (step_req),
        .step_ack   (step_ack),
        .illegal_clr(illegal_clr),
        .halted     (halted),
        .illegal    (illegal),
        .pc         (pc),
        .inst       (inst),
        .reg_sel    (reg_sel),
        .reg_rdata  (reg_rdata),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .retired    (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign inst      = pmem[pc[4:1]];
    assign reg_rdata = (reg_sel == 5'd0) ? 32'd0 : rf[reg_sel];

    always @(posedge clock) begin
        if (reg_we) rf[reg_sel] <= reg_wdata;
    end

    always @(negedge clock) begin
        if (step_ack) ack_cnt = ack_cnt + 1;
        if (reg_we)   we_cnt  = we_cnt + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (got !== exp) begin
            bad_cnt = bad_cnt + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total_cnt = 0; bad_cnt = 0; ack_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 16; i++) pmem[i] = 16'h0000;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        pmem[0] = 16'h0505;   // c.addi x10,1
        pmem[1] = 16'h157D;   // c.addi x10,-1
        pmem[2] = 16'h0001;   // c.nop (rd=0)
        pmem[3] = 16'h0505;
        pmem[4] = 16'h0505;
        pmem[5] = 16'h0000;   // illegal
        pmem[6] = 16'h0505;
        run = 1'b0; step_req = 1'b0; illegal_clr = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_value("rst_halted",  {31'd0, halted},   32'd1);
        check_value("rst_pc",      pc,                32'd0);
        check_value("rst_retired", retired,           32'd0);
        check_value("rst_illegal", {31'd0, illegal},  32'd0);
        check_value("rst_we",      {31'd0, reg_we},   32'd0);
        check_value("rst_ack",     {31'd0, step_ack}, 32'd0);
        check_value("rst_sel",     {27'd0, reg_sel},  32'd0);
        check_value("rst_wdata",   reg_wdata,         32'd0);

        // Free-run: first instruction writes back on the 3rd cycle after HALT.
        @(negedge clock);
        reset = 1'b1; run = 1'b1;
        tick(1);
        check_value("fetch_not_halted", {31'd0, halted}, 32'd0);
        tick(2);
        check_value("wb1_we",    {31'd0, reg_we},  32'd1);
        check_value("wb1_sel",   {27'd0, reg_sel}, 32'd10);
        check_value("wb1_wdata", reg_wdata,        32'd1);
        tick(1);
        check_value("i1_pc",      pc,      32'd2);
        check_value("i1_retired", retired, 32'd1);
        tick(2);
        check_value("wb2_wdata", reg_wdata,       32'd0);
        check_value("wb2_we",    {31'd0, reg_we}, 32'd1);
        tick(1);
        check_value("i2_pc", pc, 32'd4);
        tick(2);
        check_value("nop_we", {31'd0, reg_we}, 32'd0);
        run = 1'b0;
        tick(1);
        check_value("nop_halted",  {31'd0, halted}, 32'd1);
        check_value("nop_pc",      pc,              32'd6);
        check_value("nop_retired", retired,         32'd3);

        // Single step with step_req held high for 20 cycles.
        ack_base = ack_cnt;
        step_req = 1'b1;
        tick(20);
        check_value("step1_acks",    ack_cnt - ack_base, 32'd1);
        check_value("step1_retired", retired,            32'd4);
        check_value("step1_pc",      pc,                 32'd8);
        check_value("step1_halted",  {31'd0, halted},    32'd1);
        check_value("step1_x10",     rf[10],             32'd1);
        step_req = 1'b0;
        tick(1);
        ack_base = ack_cnt;
        step_req = 1'b1;
        tick(6);
        check_value("step2_acks",    ack_cnt - ack_base, 32'd1);
        check_value("step2_retired", retired,            32'd5);
        check_value("step2_pc",      pc,                 32'd10);
        step_req = 1'b0;
        tick(1);

        // Illegal encoding via step; run is then ignored until cleared.
        we_base = we_cnt; ack_base = ack_cnt;
        step_req = 1'b1;
        tick(5);
        step_req = 1'b0;
        check_value("ill_flag",    {31'd0, illegal},   32'd1);
        check_value("ill_halted",  {31'd0, halted},    32'd1);
        check_value("ill_pc",      pc,                 32'd10);
        check_value("ill_retired", retired,            32'd5);
        check_value("ill_no_we",   we_cnt - we_base,   32'd0);
        check_value("ill_no_ack",  ack_cnt - ack_base, 32'd0);
        run = 1'b1;
        tick(4);
        check_value("ill_run_halted", {31'd0, halted}, 32'd1);
        check_value("ill_run_pc",     pc,              32'd10);
        run = 1'b0;
        illegal_clr = 1'b1;
        tick(1);
        illegal_clr = 1'b0;
        check_value("ill_cleared", {31'd0, illegal}, 32'd0);

        // run dropped during EXEC: WB still happens, then HALT.
        pmem[5] = 16'h0505;
        run = 1'b1;
        tick(2);
        run = 1'b0;
        tick(1);
        check_value("drop_we",    {31'd0, reg_we}, 32'd1);
        check_value("drop_wdata", reg_wdata,       32'd3);
        tick(1);
        check_value("drop_halted", {31'd0, halted}, 32'd1);
        check_value("drop_pc",     pc,              32'd12);
        tick(3);
        check_value("drop_stay_pc",     pc,              32'd12);
        check_value("drop_stay_halted", {31'd0, halted}, 32'd1);
        check_value("drop_retired",     retired,         32'd6);

        // Asynchronous reset in the middle of WB.
        run = 1'b1;
        tick(3);
        check_value("rwb_we_before", {31'd0, reg_we}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check_value("rwb_we",      {31'd0, reg_we}, 32'd0);
        check_value("rwb_pc",      pc,              32'd0);
        check_value("rwb_retired", retired,         32'd0);
        check_value("rwb_halted",  {31'd0, halted}, 32'd1);
        tick(1);
        check_value("rwb_x10_kept", rf[10], 32'd3);
        reset = 1'b1;

        // C.LI x10,5 at pc 0: legal only when the option is built in.
        pmem[0] = 16'h4515;
        tick(3);
`ifdef SEQ_C_LI_EN
        check_value("cli_we",    {31'd0, reg_we}, 32'd1);
        check_value("cli_wdata", reg_wdata,       32'd5);
`else
        check_value("cli_illegal", {31'd0, illegal}, 32'd1);
        check_value("cli_pc",      pc,               32'd0);
`endif
        run = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
